// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Drives the rPLL RESET input, qualifies its LOCK output and holds the
//   downstream system reset until the PLL output clock can be trusted.
//   Runs entirely on the reference oscillator clock (the PLL clkin net).
//   Sequence: PRST (timed PLL reset) -> WAIT (lock pending) -> STAB (lock
//   must stay high) -> RUN. A lock timeout retries from PRST until the
//   retry budget is spent, then parks in FAIL until clear_fail.
//   Optional feature macro: PLL_LOCK_GLITCH_FILTER_EN
//     defined   : a loss in RUN needs GLITCH_CYC consecutive low lock samples
//     undefined : the first low lock sample in RUN is a loss (GLITCH_CYC unused)

module pll_lock_supervisor #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 270000,
  parameter int MAX_RETRY        = 3,
  parameter int GLITCH_CYC       = 8,
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_lock,
  input  logic               clear_fail,
  output logic               pll_reset,
  output logic               sys_rst,
  output logic               locked,
  output logic               fail,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int RST_W  = (RST_PULSE_CYC > 1)    ? $clog2(RST_PULSE_CYC)    : 1;
  localparam int STAB_W = (LOCK_STABLE_CYC > 1)  ? $clog2(LOCK_STABLE_CYC)  : 1;
  localparam int TMO_W  = (LOCK_TIMEOUT_CYC > 1) ? $clog2(LOCK_TIMEOUT_CYC) : 1;

  localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(RST_PULSE_CYC - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  // The WAIT cycle that first sees lock high already counts as stable cycle
  // one, so STAB only has to collect LOCK_STABLE_CYC-1 further cycles; with
  // LOCK_STABLE_CYC of one, WAIT goes straight to RUN.
  localparam logic [STAB_W-1:0]  STAB_LAST = STAB_W'((LOCK_STABLE_CYC > 1) ? LOCK_STABLE_CYC - 2 : 0);
  localparam bit                 STAB_SKIP = (LOCK_STABLE_CYC == 1);

  // Reject parameter values the sequencer cannot honour.
  if (RST_PULSE_CYC < 1 || LOCK_STABLE_CYC < 1 || LOCK_TIMEOUT_CYC < 2 ||
      MAX_RETRY < 0 || GLITCH_CYC < 1) begin : g_param_check
    $error("pll_lock_supervisor: parameter out of range");
  end

  typedef enum logic [2:0] {
    ST_PRST,
    ST_WAIT,
    ST_STAB,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t               state_q, state_d;
  logic                 lock_meta_q, lock_meta_d;
  logic                 lock_s_q, lock_s_d;
  logic [RST_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic [STAB_W-1:0]    stab_cnt_q, stab_cnt_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 pll_reset_q, pll_reset_d;
  logic                 sys_rst_q, sys_rst_d;
  logic                 locked_q, locked_d;
  logic                 fail_q, fail_d;
  logic                 lock_lost_q, lock_lost_d;
  logic                 loss_evt;
  logic                 timeout;
  logic                 was_waiting;
  logic                 now_waiting;

  // Two-stage synchroniser path for the asynchronous LOCK input.
  always_comb begin
    lock_meta_d = pll_lock;
    lock_s_d    = lock_meta_q;
  end

`ifdef PLL_LOCK_GLITCH_FILTER_EN
  localparam int GLITCH_W = (GLITCH_CYC > 1) ? $clog2(GLITCH_CYC) : 1;
  localparam logic [GLITCH_W-1:0] GLITCH_LAST = GLITCH_W'(GLITCH_CYC - 1);

  logic [GLITCH_W-1:0] glitch_cnt_q, glitch_cnt_d;

  // Loss filter: only a run of GLITCH_CYC low lock samples in RUN is a loss.
  always_comb begin
    glitch_cnt_d = '0;
    loss_evt     = 1'b0;
    if (state_q == ST_RUN && !lock_s_q) begin
      if (glitch_cnt_q == GLITCH_LAST) begin
        loss_evt = 1'b1;
      end else begin
        glitch_cnt_d = glitch_cnt_q + GLITCH_W'(1);
      end
    end
  end

  // Filter counter register; idles at zero outside RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_cnt_q <= '0;
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
    end
  end
`else
  // Without the filter any low lock sample in RUN is a loss.
  always_comb begin
    loss_evt = (state_q == ST_RUN) && !lock_s_q;
  end
`endif

  // Next-state and counter logic for the lock sequencer.
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    stab_cnt_d = stab_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    retry_d    = retry_q;
    timeout    = (tmo_cnt_q == TMO_LAST);

    case (state_q)
      ST_PRST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = ST_WAIT;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end

      ST_WAIT, ST_STAB: begin
        if (timeout) begin
          // Timeout takes priority over any lock progress this cycle.
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_PRST;
          end else begin
            state_d = ST_FAIL;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          if (state_q == ST_WAIT) begin
            if (lock_s_q) begin
              if (STAB_SKIP) begin
                state_d = ST_RUN;
                retry_d = '0;
              end else begin
                state_d = ST_STAB;
              end
            end
          end else begin
            if (!lock_s_q) begin
              state_d = ST_WAIT;
            end else if (stab_cnt_q == STAB_LAST) begin
              state_d = ST_RUN;
              retry_d = '0;
            end else begin
              stab_cnt_d = stab_cnt_q + STAB_W'(1);
            end
          end
        end
      end

      ST_RUN: begin
        if (loss_evt) begin
          state_d = ST_PRST;
          retry_d = '0;
        end
      end

      ST_FAIL: begin
        if (clear_fail) begin
          state_d = ST_PRST;
          retry_d = '0;
        end
      end

      default: begin
        state_d = ST_PRST;
        retry_d = '0;
      end
    endcase

    // Every state entry starts its counters from zero; only the timeout
    // counter survives the WAIT<->STAB bounce so chatter cannot stall it.
    was_waiting = (state_q == ST_WAIT) || (state_q == ST_STAB);
    now_waiting = (state_d == ST_WAIT) || (state_d == ST_STAB);
    if (state_d != state_q) begin
      rst_cnt_d  = '0;
      stab_cnt_d = '0;
      if (!(was_waiting && now_waiting)) begin
        tmo_cnt_d = '0;
      end
    end
  end

  // Output decode from the next state so every output is a clean flop.
  always_comb begin
    pll_reset_d = (state_d == ST_PRST) || (state_d == ST_FAIL);
    sys_rst_d   = (state_d != ST_RUN);
    locked_d    = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
    lock_lost_d = (state_q == ST_RUN) && (state_d == ST_PRST);
  end

  // Sequencer, synchroniser and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PRST;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      rst_cnt_q   <= '0;
      stab_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      rst_cnt_q   <= rst_cnt_d;
      stab_cnt_q  <= stab_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_q   <= sys_rst_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign sys_rst   = sys_rst_q;
  assign locked    = locked_q;
  assign fail      = fail_q;
  assign lock_lost = lock_lost_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
//   Directed bench for pll_lock_supervisor with small timing parameters
//   (pulse 4, stable 8, timeout 32, two retries, glitch length 3).
//   Inputs change 1 time unit after a rising edge; outputs are sampled at
//   the same point, so edge En below means "just after the n-th edge".

module tb_pll_lock_supervisor;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       clear_fail;
  logic       pll_reset;
  logic       sys_rst;
  logic       locked;
  logic       fail;
  logic       lock_lost;
  logic [1:0] retry_cnt;

  int checkCount = 0;
  int errorCount = 0;

  pll_lock_supervisor #(
    .RST_PULSE_CYC   (4),
    .LOCK_STABLE_CYC (8),
    .LOCK_TIMEOUT_CYC(32),
    .MAX_RETRY       (2),
    .GLITCH_CYC      (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_lock  (pll_lock),
    .clear_fail(clear_fail),
    .pll_reset (pll_reset),
    .sys_rst   (sys_rst),
    .locked    (locked),
    .fail      (fail),
    .lock_lost (lock_lost),
    .retry_cnt (retry_cnt)
  );

  // 10-unit reference clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag, input logic expReset, input logic expSys,
                          input logic expLocked, input logic expFail, input logic expLost,
                          input logic [1:0] expRetry);
    checkOutput({tag, ".pll_reset"}, 32'(pll_reset), 32'(expReset));
    checkOutput({tag, ".sys_rst"},   32'(sys_rst),   32'(expSys));
    checkOutput({tag, ".locked"},    32'(locked),    32'(expLocked));
    checkOutput({tag, ".fail"},      32'(fail),      32'(expFail));
    checkOutput({tag, ".lock_lost"}, 32'(lock_lost), 32'(expLost));
    checkOutput({tag, ".retry_cnt"}, 32'(retry_cnt), 32'(expRetry));
  endtask

  task automatic applyStimulus(input logic lockIn, input logic clearIn);
    pll_lock   = lockIn;
    clear_fail = clearIn;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Assert reset, check reset values, release just after an edge.
  task automatic startReset(input string tag);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    #1;
    checkAll(tag, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(2);
    rst = 1'b0;
  endtask

  // Normal bring-up from a fresh release with lock low.
  task automatic bringUp(input string tag);
    tick(3);
    checkOutput({tag, ".prst_e3"}, 32'(pll_reset), 32'd1);
    tick(1);
    checkOutput({tag, ".prst_e4"}, 32'(pll_reset), 32'd0);
    tick(2);
    applyStimulus(1'b1, 1'b0);
    tick(9);
    checkAll({tag, ".pre_run"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(1);
    checkAll({tag, ".run"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);

    // Test 1: normal bring-up
    startReset("t1.reset");
    bringUp("t1");

    // Test 4: loss in RUN; clear_fail outside FAIL is ignored first
    tick(3);
    applyStimulus(1'b1, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b0);
    checkAll("t4.clear_ignored", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
`ifdef PLL_LOCK_GLITCH_FILTER_EN
    applyStimulus(1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b0);
    tick(2);
    checkAll("t4.short_drop_d3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    tick(2);
    checkAll("t4.short_drop_d5", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0);
    tick(3);
    applyStimulus(1'b1, 1'b0);
    tick(1);
    checkOutput("t4.filtering_locked", 32'(locked), 32'd1);
    tick(1);
    checkAll("t4.loss", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    tick(3);
    checkOutput("t4.prst_hold", 32'(pll_reset), 32'd1);
    tick(1);
    checkOutput("t4.prst_end", 32'(pll_reset), 32'd0);
`else
    applyStimulus(1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b0);
    tick(1);
    checkOutput("t4.before_loss", 32'(locked), 32'd1);
    tick(1);
    checkAll("t4.loss", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    tick(1);
    checkOutput("t4.lost_pulse_end", 32'(lock_lost), 32'd0);
    tick(2);
    checkOutput("t4.prst_hold", 32'(pll_reset), 32'd1);
    tick(1);
    checkOutput("t4.prst_end", 32'(pll_reset), 32'd0);
    tick(7);
    checkOutput("t4.relock_pre", 32'(locked), 32'd0);
    tick(1);
    checkAll("t4.relock", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
`endif

    // Test 2: lock never rises -> retries then FAIL, then clear_fail
    startReset("t2.reset");
    tick(4);
    checkOutput("t2.p1_end", 32'(pll_reset), 32'd0);
    tick(31);
    checkAll("t2.before_to1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(1);
    checkAll("t2.to1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    tick(3);
    checkOutput("t2.p2_hold", 32'(pll_reset), 32'd1);
    tick(1);
    checkOutput("t2.p2_end", 32'(pll_reset), 32'd0);
    tick(31);
    checkOutput("t2.before_to2", 32'(pll_reset), 32'd0);
    tick(1);
    checkAll("t2.to2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    tick(4);
    checkOutput("t2.p3_end", 32'(pll_reset), 32'd0);
    tick(31);
    checkAll("t2.before_fail", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    tick(1);
    checkAll("t2.fail", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2);
    tick(10);
    checkAll("t2.fail_hold", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2);
    applyStimulus(1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0);
    checkAll("t2.cleared", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(3);
    checkOutput("t2.restart_hold", 32'(pll_reset), 32'd1);
    tick(1);
    checkOutput("t2.restart_end", 32'(pll_reset), 32'd0);

    // Test 3: lock chatter in STAB restarts the stability count
    startReset("t3.reset");
    tick(4);
    applyStimulus(1'b1, 1'b0);
    tick(5);
    applyStimulus(1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b0);
    tick(4);
    checkOutput("t3.no_early_release", 32'(locked), 32'd0);
    tick(5);
    checkAll("t3.pre_run", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(1);
    checkAll("t3.run", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

    // Test 5: async reset in STAB, then in RUN
    startReset("t5.reset");
    tick(6);
    applyStimulus(1'b1, 1'b0);
    tick(5);
    checkAll("t5.in_stab", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    #1;
    checkAll("t5.stab_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(1);
    rst = 1'b0;
    bringUp("t5a");
    tick(2);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    #1;
    checkAll("t5.run_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(1);
    rst = 1'b0;
    bringUp("t5b");

    // Test 6: lock arrives on the timeout edge; timeout wins
    startReset("t6.reset");
    tick(4);
    tick(29);
    applyStimulus(1'b1, 1'b0);
    tick(2);
    checkAll("t6.before_to", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(1);
    checkAll("t6.to_wins", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    tick(4);
    checkOutput("t6.prst_end", 32'(pll_reset), 32'd0);
    tick(7);
    checkOutput("t6.pre_run", 32'(locked), 32'd0);
    tick(1);
    checkAll("t6.run", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
